// File: rtl/sha_const.sv
// Shared constants and types for the sha core and its request arbiter.
// Message is one Nl-byte block; digest is Nk bits.
// No logic lives here; types only.
package sha_const;

  localparam int Nl = 64;
  localparam int Nk = 256;
  localparam int NR_DEFAULT = 4;

  typedef logic [Nl-1:0][7:0] msg_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/sha_arbiter_rr_pick.sv
// Round-robin picker: first request strictly after last_grant, wrapping.
// Purely combinational; the caller registers the result.
// No backpressure; valid is low when no request is pending.
module sha_arbiter_rr_pick
  import sha_const::*;
#(
  parameter int Nr = NR_DEFAULT,
  parameter int LW = (Nr > 1) ? $clog2(Nr) : 1
) (
  input  logic [Nr-1:0] req,
  input  logic [LW-1:0] last_grant,
  output logic [Nr-1:0] grant,
  output logic [LW-1:0] grant_idx,
  output logic          valid
);

  // One extra bit so last_grant + Nr never overflows before the wrap.
  logic [LW:0] pos;

  // Scan positions last_grant+1 .. last_grant+Nr and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    pos       = '0;
    for (int i = 1; i <= Nr; i++) begin
      pos = {1'b0, last_grant} + (LW+1)'(i);
      if (pos >= (LW+1)'(Nr)) pos = pos - (LW+1)'(Nr);
      if (!valid && req[pos[LW-1:0]]) begin
        valid                = 1'b1;
        grant[pos[LW-1:0]]   = 1'b1;
        grant_idx            = pos[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/sha_arbiter.sv
// Shares one sha core among Nr requesters, round-robin, with a WAIT watchdog.
// Ack/Sha_enable one cycle after Req is sampled; Done one cycle after Sha_ready.
// Requests are held off (no Ack) while a job is in flight; Req must hold until Ack.
module sha_arbiter
  import sha_const::*;
#(
  parameter int Nr      = NR_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Nr-1:0]        Req,
  input  msg_t [Nr-1:0]        Req_data,
  output logic [Nr-1:0]        Ack,
  output logic [Nr-1:0]        Done,
  output logic                 Err,
  output logic [Nk-1:0]        Hash_out,
  output logic                 Busy,
  output msg_t                 Sha_data,
  output logic                 Sha_enable,
  input  logic [Nk-1:0]        Sha_hash,
  input  logic                 Sha_ready
);

  localparam int LW = (Nr > 1) ? $clog2(Nr) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] last_grant;
  logic [LW-1:0] owner;

  logic [Nr-1:0] pick_grant;
  logic [LW-1:0] pick_idx;
  logic          pick_vld;

  sha_arbiter_rr_pick #(.Nr(Nr), .LW(LW)) u_pick (
    .req        (Req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .valid      (pick_vld)
  );

  // Job sequencer: grant in IDLE, strobe the core in ISSUE, collect or time out in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LW'(Nr - 1);
      owner      <= '0;
      Ack        <= '0;
      Done       <= '0;
      Err        <= 1'b0;
      Hash_out   <= '0;
      Busy       <= 1'b0;
      Sha_data   <= '0;
      Sha_enable <= 1'b0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      Ack        <= '0;
      Done       <= '0;
      Err        <= 1'b0;
      Sha_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            Sha_data   <= Req_data[pick_idx];
            owner      <= pick_idx;
            Ack        <= pick_grant;
            Sha_enable <= 1'b1;
            Busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        // A Ready seen here belongs to no job of ours and is dropped.
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (Sha_ready) begin
            Hash_out   <= Sha_hash;
            Done       <= Nr'(1) << owner;
            last_grant <= owner;
            Busy       <= 1'b0;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            Hash_out   <= '0;
            Done       <= Nr'(1) << owner;
            Err        <= 1'b1;
            last_grant <= owner;
            Busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            // Never wraps: the compare above leaves WAIT before the top value.
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_arbiter.sv
module tb_sha_arbiter;
  import sha_const::*;

  localparam int NR  = 4;
  localparam int TMO = 8;
  localparam logic [Nk-1:0] MAGIC = {8{32'hA0A0_5A5A}};

  logic                clk;
  logic                rst;
  logic [NR-1:0]       req;
  logic [NR-1:0][Nl*8-1:0] req_data;
  logic [NR-1:0]       Ack;
  logic [NR-1:0]       Done;
  logic                Err;
  logic [Nk-1:0]       Hash_out;
  logic                Busy;
  logic [Nl*8-1:0]     Sha_data;
  logic                Sha_enable;
  logic [Nk-1:0]       Sha_hash;
  logic                Sha_ready;

  int checks = 0;
  int errors = 0;

  // Stub core controls and state.
  int   stub_lat   = 5;   // cycles from Enable to Ready; 0 = never answer
  logic stub_stray = 1'b0;
  logic stub_pending = 1'b0;
  int   stub_since = 0;

  // Reference model state.
  logic [Nl*8-1:0] mdl_data [NR];
  int mdl_lg;

  sha_arbiter #(.Nr(NR), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .Req        (req),
    .Req_data   (req_data),
    .Ack        (Ack),
    .Done       (Done),
    .Err        (Err),
    .Hash_out   (Hash_out),
    .Busy       (Busy),
    .Sha_data   (Sha_data),
    .Sha_enable (Sha_enable),
    .Sha_hash   (Sha_hash),
    .Sha_ready  (Sha_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stub core: Ready stub_lat cycles after the Enable cycle.
  always begin
    @(posedge clk);
    #1;
    Sha_ready = 1'b0;
    if (Sha_enable) begin
      stub_since   = 0;
      stub_pending = 1'b1;
      if (stub_stray) Sha_ready = 1'b1;
    end else if (stub_pending) begin
      stub_since++;
      if (stub_lat != 0 && stub_since == stub_lat) begin
        Sha_ready    = 1'b1;
        Sha_hash     = Sha_data[Nk-1:0] ^ MAGIC;
        stub_pending = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (Ack == '0 && cyc < 60);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (Done == '0 && cyc < 60);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    mdl_lg = NR - 1;
  endtask

  task automatic new_data(input int k);
    for (int w = 0; w < Nl / 4; w++) mdl_data[k][w*32 +: 32] = $urandom();
    req_data[k] = mdl_data[k];
  endtask

  // Round-robin rule stated directly: first requester after the last owner.
  function automatic int mdl_pick(input logic [NR-1:0] m, input int lg);
    for (int i = 1; i <= NR; i++) begin
      if (m[(lg + i) % NR]) return (lg + i) % NR;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    step();
    step();
    checks++;
    if ({Ack, Done, Err, Busy, Sha_enable} !== '0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0", {Ack, Done, Err, Busy, Sha_enable});
    end
    checks++;
    if (Hash_out !== '0 || Sha_data !== '0) begin
      errors++;
      $display("FAIL reset_data hash %h data %h want 0", Hash_out, Sha_data);
    end
    rst = 1'b1;
    step();
    mdl_lg = NR - 1;
  endtask

  task automatic test_single();
    int c;
    stub_lat = 5;
    mdl_data[0] = {24'h616263, 8'h80, 416'b0, 64'd24};
    req_data[0] = mdl_data[0];
    req = 4'b0001;
    wait_ack(c);
    checks++;
    if (c != 1 || Ack !== 4'b0001 || Sha_enable !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack cyc %0d ack %b en %b busy %b want 1 0001 1 1", c, Ack, Sha_enable, Busy);
    end
    checks++;
    if (Sha_data !== mdl_data[0]) begin
      errors++;
      $display("FAIL single_data got %h want %h", Sha_data, mdl_data[0]);
    end
    req = '0;
    wait_done(c);
    checks++;
    if (c != stub_lat + 1 || Done !== 4'b0001 || Err !== 1'b0) begin
      errors++;
      $display("FAIL single_done cyc %0d done %b err %b want %0d 0001 0", c, Done, Err, stub_lat + 1);
    end
    checks++;
    if (Hash_out !== (mdl_data[0][Nk-1:0] ^ MAGIC)) begin
      errors++;
      $display("FAIL single_hash got %h want %h", Hash_out, mdl_data[0][Nk-1:0] ^ MAGIC);
    end
    step();
    checks++;
    if (Done !== '0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after done %b busy %b want 0000 0", Done, Busy);
    end
    mdl_lg = 0;
  endtask

  task automatic test_simultaneous();
    int c;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] exp_oh;
    pulse_reset();
    stub_lat = 5;
    for (int k = 0; k < NR; k++) begin
      mdl_data[k] = (Nl*8)'(32'hA0 + k);
      req_data[k] = mdl_data[k];
    end
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_oh = 4'(1) << exp_order[j];
      wait_ack(c);
      checks++;
      if (c != 1 || Ack !== exp_oh) begin
        errors++;
        $display("FAIL simul_ack job %0d cyc %0d ack %b want 1 %b", j, c, Ack, exp_oh);
      end
      if (j == 4) req = '0;
      wait_done(c);
      checks++;
      if (c != stub_lat + 1 || Done !== exp_oh || Hash_out !== ((Nk'(32'hA0 + exp_order[j])) ^ MAGIC)) begin
        errors++;
        $display("FAIL simul_done job %0d cyc %0d done %b hash %h want %b", j, c, Done, Hash_out, exp_oh);
      end
    end
    mdl_lg = 0;
  endtask

  task automatic test_wrap();
    int c;
    stub_lat = 2;
    req = 4'b0100;
    wait_ack(c);
    req = '0;
    wait_done(c);
    checks++;
    if (Done !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_first done %b want 0100", Done);
    end
    req = 4'b0101;
    wait_ack(c);
    checks++;
    if (Ack !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_order ack %b want 0001", Ack);
    end
    req = 4'b0100;
    wait_done(c);
    wait_ack(c);
    checks++;
    if (c != 1 || Ack !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_second cyc %0d ack %b want 1 0100", c, Ack);
    end
    req = '0;
    wait_done(c);
    mdl_lg = 2;
  endtask

  task automatic test_timeout();
    int c;
    stub_lat = 0;
    req = 4'b0010;
    wait_ack(c);
    req = '0;
    wait_done(c);
    checks++;
    if (c != TMO + 1 || Done !== 4'b0010 || Err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done cyc %0d done %b err %b want %0d 0010 1", c, Done, Err, TMO + 1);
    end
    checks++;
    if (Hash_out !== '0) begin
      errors++;
      $display("FAIL timeout_hash got %h want 0", Hash_out);
    end
    stub_lat = 3;
    new_data(3);
    req = 4'b1000;
    wait_ack(c);
    checks++;
    if (c != 1 || Ack !== 4'b1000 || Err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_ack cyc %0d ack %b err %b want 1 1000 0", c, Ack, Err);
    end
    req = '0;
    wait_done(c);
    checks++;
    if (c != 4 || Err !== 1'b0 || Hash_out !== (mdl_data[3][Nk-1:0] ^ MAGIC)) begin
      errors++;
      $display("FAIL timeout_next_done cyc %0d err %b hash %h", c, Err, Hash_out);
    end
    mdl_lg = 3;
  endtask

  task automatic test_reset_mid_wait();
    int c;
    int seen;
    stub_lat = 0;
    req = 4'b0100;
    wait_ack(c);
    req = '0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== '0 || Sha_enable !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs busy %b done %b en %b want 0", Busy, Done, Sha_enable);
    end
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Done !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_nodone saw %0d done cycles want 0", seen);
    end
    stub_lat = 2;
    req = 4'b0010;
    wait_ack(c);
    checks++;
    if (Ack !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_regrant ack %b want 0010", Ack);
    end
    req = '0;
    wait_done(c);
    mdl_lg = 1;
  endtask

  task automatic test_stray_ready();
    int c;
    int extra;
    stub_stray = 1'b1;
    stub_lat = 3;
    req = 4'b0001;
    wait_ack(c);
    req = '0;
    wait_done(c);
    checks++;
    if (c != 4 || Done !== 4'b0001) begin
      errors++;
      $display("FAIL stray_done cyc %0d done %b want 4 0001", c, Done);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (Done !== '0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL stray_extra saw %0d extra done want 0", extra);
    end
    stub_stray = 1'b0;
    mdl_lg = 0;
  endtask

  task automatic test_random();
    int c;
    int w;
    int lat;
    int waits [NR];
    logic [NR-1:0] pend;
    logic [NR-1:0] exp_oh;
    logic [Nk-1:0] exp_hash;
    pulse_reset();
    pend = '0;
    for (int k = 0; k < NR; k++) waits[k] = 0;
    for (int j = 0; j < 40; j++) begin
      if (pend == '0) begin
        pend = 4'($urandom_range(1, 15));
        for (int k = 0; k < NR; k++) if (pend[k]) new_data(k);
      end
      lat = $urandom_range(1, 6);
      stub_lat = lat;
      req = pend;
      w = mdl_pick(pend, mdl_lg);
      exp_oh = 4'(1) << w;
      exp_hash = mdl_data[w][Nk-1:0] ^ MAGIC;
      wait_ack(c);
      checks++;
      if (c != 1 || Ack !== exp_oh || Sha_data !== mdl_data[w]) begin
        errors++;
        $display("FAIL rand_ack job %0d cyc %0d ack %b want %b", j, c, Ack, exp_oh);
      end
      for (int k = 0; k < NR; k++) begin
        if (pend[k] && k != w) begin
          waits[k]++;
          checks++;
          if (waits[k] > NR - 1) begin
            errors++;
            $display("FAIL rand_fair req %0d waited %0d jobs want <= %0d", k, waits[k], NR - 1);
          end
        end
      end
      waits[w] = 0;
      if ($urandom_range(0, 1) == 0) pend[w] = 1'b0;
      else new_data(w);
      for (int k = 0; k < NR; k++) begin
        if (k != w && !pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          waits[k] = 0;
          new_data(k);
        end
      end
      req = pend;
      wait_done(c);
      checks++;
      if (c != lat + 1 || Done !== exp_oh || Err !== 1'b0 || Hash_out !== exp_hash) begin
        errors++;
        $display("FAIL rand_done job %0d cyc %0d done %b err %b hash %h want %0d %b 0 %h",
                 j, c, Done, Err, Hash_out, lat + 1, exp_oh, exp_hash);
      end
      mdl_lg = w;
    end
    req = '0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_data = '0;
    Sha_ready = 1'b0;
    Sha_hash = '1;
    for (int k = 0; k < NR; k++) mdl_data[k] = '0;
    mdl_lg = NR - 1;
    test_reset();
    test_single();
    test_simultaneous();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_stray_ready();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_arbiter.md
Name: sha_arbiter

Overview:
Round-robin controller that shares one `sha` hash core among Nr requesters. It latches a requester's Nl-byte message, pulses the core's Enable for exactly one cycle and waits for Ready. It then returns the hash with a one-cycle Done pulse to the owning requester. A watchdog aborts a job if the core never answers. It sits between the `sha` instance and its clients, in place of the single-user test sequencer.

Parameters:
Nr, 4, number of requesters (2..16)
TIMEOUT, 1024, max cycles spent in WAIT before the job is aborted (>=2)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
Req  in  Nr  per-requester request; must hold until matching Ack
Req_data  in  Nr x Nl x 8  per-requester message bytes, valid while Req high
Ack  out  Nr  one-hot pulse: request accepted and data latched
Done  out  Nr  one-hot pulse: Hash_out valid for this requester
Err  out  1  pulse with Done when the job timed out
Hash_out  out  Nk  result, held until next Done
Busy  out  1  high whenever state != IDLE
Sha_data  out  Nl x 8  message to core, held stable ISSUE..WAIT
Sha_enable  out  1  core start strobe
Sha_hash  in  Nk  core result
Sha_ready  in  1  core completion strobe

Behaviour:
- Reset values:
  - Ack, Done, Err, Sha_enable, Busy = 0; Hash_out, Sha_data = 0.
  - State = IDLE; wait counter = 0; last_grant = Nr-1, so requester 0 has first priority.
- All outputs are registered. Reset asserted mid-job aborts it immediately; no Done is issued. The core shares rst.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE, some Req high:
    - winner = first set bit scanning upward from last_grant+1, wrapping modulo Nr.
    - Next edge: Req_data[winner] -> Sha_data; owner index latched; Ack[winner]=1 for one cycle; Sha_enable=1; state -> ISSUE.
  - IDLE, no Req: outputs idle, state stays IDLE.
  - ISSUE: lasts exactly one cycle, with Sha_enable high and Ack coincident. Next edge: Sha_enable=0, counter=0, state -> WAIT.
  - WAIT, Sha_ready=1: next edge Hash_out <= Sha_hash, Done[owner]=1, last_grant <= owner, state -> IDLE.
  - WAIT, Sha_ready=0 and counter==TIMEOUT-1: next edge Done[owner]=1, Err=1, Hash_out <= 0, last_grant <= owner, state -> IDLE.
  - WAIT, otherwise: counter increments; it saturates and never wraps.
  - Sha_ready is ignored outside WAIT. A Ready arriving in the ISSUE cycle is dropped.
- Latency:
  - Req sampled at edge T0 gives Ack and Sha_enable during cycle T0+1.
  - Done appears the cycle after the cycle in which Sha_ready was high.
- Back-to-back: in the cycle Done is high, state is already IDLE and may grant again. The minimum issue-to-issue gap is core latency + 2 cycles.
- Requester rules:
  - Requesters deassert Req, or present new data, on the cycle after Ack.
  - Req dropped before Ack: the request is not served and nothing is latched.
  - Req changes outside IDLE are ignored.
- Fairness: a requester holding Req waits at most Nr-1 jobs.

Decomposition:
- Package sha_const: Nl, Nk (existing); add typedef for a message byte array, Nr default, and FSM state enum (IDLE, ISSUE, WAIT).
- Sub-module rr_pick: combinational Nr-bit round-robin picker (Req, last_grant -> one-hot grant, valid); the arbiter registers its result.

Test Plan:
- Single request: Req=0001, Req_data[0]="abc" padded, real sha core -> Ack=0001 and Sha_enable in the same cycle, then Done=0001. With SHA-256, Hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and Err=0.
- Simultaneous requests: Req=1111 held, with a stub core replying Ready 5 cycles after Enable and returning 32'hA0+index -> grant order 0,1,2,3,0, and each Done carries the matching value.
- Wrap-around: after serving 2, Req=0101 -> requester 0 is granted before 2.
- Timeout: stub never raises Ready, TIMEOUT=8 -> Done[owner] and Err high together exactly 8 WAIT cycles after ISSUE, Hash_out=0, then the next request is granted normally.
- Reset mid-WAIT: rst=0 for one cycle during WAIT -> Busy=0, no Done; a subsequent Req=0010 yields Ack=0010, since last_grant is reset.
- Stray Ready: stub asserts Ready in the ISSUE cycle and again 3 cycles later -> exactly one Done, after the second Ready.
